// File: rtl/gmac_tx_framer_if.sv
// Byte-write / transmit handshake bundle between a frame producer and gmac_tx_framer.
interface gmac_tx_framer_if;
  localparam int unsigned DATA_W = 8;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              gmac_tx_ready;
  logic [DATA_W-1:0] gmac_tx_data;
  logic              gmac_tx_dvld;
  logic              busy;
  logic              full;
  logic              done;

  modport master (
    output wr_en, wr_data, start, gmac_tx_ready,
    input  gmac_tx_data, gmac_tx_dvld, busy, full, done
  );

  modport slave (
    input  wr_en, wr_data, start, gmac_tx_ready,
    output gmac_tx_data, gmac_tx_dvld, busy, full, done
  );
endinterface

// File: rtl/gmac_tx_framer.sv
// Buffers one frame of bytes, streams it out under ready/valid, then holds off
// for a fixed inter-frame gap before accepting the next frame.
module gmac_tx_framer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IFG   = 12
) (
  input  logic             txcoreclk,
  input  logic             reset,
  gmac_tx_framer_if.slave  bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned GAP_W  = 8;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] IFG_CNT   = GAP_W'(IFG);
  localparam logic [PTR_W-1:0] PTR_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [DATA_W-1:0] buf_mem [DEPTH];

  state_e            state_q,  state_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [GAP_W-1:0]  gap_q,    gap_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              dvld_q,   dvld_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic              full_c;
  logic              mem_we_c;
  logic [PTR_W-1:0]  rd_next_c;

  assign full_c    = (count_q == DEPTH_CNT);
  assign rd_next_c = rd_ptr_q + PTR_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    gap_d     = gap_q;
    data_d    = data_q;
    dvld_d    = dvld_q;
    done_d    = 1'b0;
    mem_we_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (count_q != '0)) begin
          state_d  = ST_SEND;
          rd_ptr_d = PTR_ZERO;
          data_d   = buf_mem[PTR_ZERO];
          dvld_d   = 1'b1;
        end else if (bus.wr_en && !full_c) begin
          mem_we_c = 1'b1;
          count_d  = count_q + CNT_W'(1);
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end

      ST_SEND: begin
        if (bus.gmac_tx_ready) begin
          if (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1))) begin
            state_d = ST_GAP;
            dvld_d  = 1'b0;
            gap_d   = IFG_CNT;
            done_d  = (IFG_CNT == GAP_W'(1));
          end else begin
            rd_ptr_d = rd_next_c;
            data_d   = buf_mem[rd_next_c];
          end
        end
      end

      ST_GAP: begin
        // done is raised one edge early so it lines up with the final gap cycle.
        if (gap_q <= GAP_W'(1)) begin
          state_d  = ST_IDLE;
          count_d  = '0;
          wr_ptr_d = PTR_ZERO;
          rd_ptr_d = PTR_ZERO;
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          done_d = (gap_q == GAP_W'(2));
        end
      end

      default: begin
        state_d = ST_IDLE;
        dvld_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge txcoreclk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      gap_q    <= '0;
      data_q   <= '0;
      dvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      dvld_q   <= dvld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Frame storage; contents survive reset and frame completion.
  always_ff @(posedge txcoreclk) begin
    if (mem_we_c) begin
      buf_mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.gmac_tx_data = data_q;
  assign bus.gmac_tx_dvld = dvld_q;
  assign bus.busy         = busy_q;
  assign bus.full         = full_c;
  assign bus.done         = done_q;

endmodule
